// File: rtl/chunked_serial_adder.sv
// Multi-cycle WIDTH-bit adder that sums CHUNK bits per clock with a registered carry.
// Optional subtract mode (port sub) is enabled by defining SERIAL_ADDER_SUBTRACT_EN.
module chunked_serial_adder #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
`ifdef SERIAL_ADDER_SUBTRACT_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int unsigned CW     = CHUNK + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_cfg
        $error("chunked_serial_adder: WIDTH must be a non-zero multiple of CHUNK");
    end

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
    logic             carry_q, carry_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             c_out_q, c_out_d, ovf_q, ovf_d;
    logic             busy_q, busy_d, done_q, done_d;

    logic [CW-1:0]    csum;
    logic             msb_cin;
    logic [WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    // Operands shift right each BUSY cycle so the active chunk is always bits [CHUNK-1:0].
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;

`ifdef SERIAL_ADDER_SUBTRACT_EN
        b_eff   = sub ? ~b : b;
        cin_eff = sub ? 1'b1 : c_in;
`else
        b_eff   = b;
        cin_eff = c_in;
`endif

        csum    = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + CW'(carry_q);
        msb_cin = a_q[CHUNK-1] ^ b_q[CHUNK-1] ^ csum[CHUNK-1];
        acc_nxt = (acc_q >> CHUNK) | (WIDTH'(csum[CHUNK-1:0]) << (WIDTH - CHUNK));

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b_eff;
                    carry_d = cin_eff;
                    idx_d   = '0;
                    acc_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                a_d     = a_q >> CHUNK;
                b_d     = b_q >> CHUNK;
                acc_d   = acc_nxt;
                carry_d = csum[CHUNK];
                idx_d   = idx_q + IDXW'(1);
                if (idx_q == IDXW'(NCHUNK - 1)) begin
                    state_d = DONE;
                    sum_d   = acc_nxt;
                    c_out_d = csum[CHUNK];
                    ovf_d   = msb_cin ^ csum[CHUNK];
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign sum      = sum_q;
    assign c_out    = c_out_q;
    assign overflow = ovf_q;

endmodule
